// File: rtl/ysyx_22041211_mem_arbiter_if.sv
// Bundle of IFU, LSU and shared-SRAM signals around the memory arbiter.
// The arbiter serves the requesters and drives the SRAM, so it uses the
// slave view; the surrounding core/SRAM (or a testbench) uses the master view.
interface ysyx_22041211_mem_arbiter_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    // IFU side
    logic                ifu_req_valid;
    logic [ADDR_LEN-1:0] ifu_addr;
    logic                ifu_req_ready;
    logic                ifu_rvalid;
    logic [DATA_LEN-1:0] ifu_rdata;
    // LSU side
    logic                lsu_req_valid;
    logic                lsu_wen;
    logic [ADDR_LEN-1:0] lsu_addr;
    logic [DATA_LEN-1:0] lsu_wdata;
    logic [7:0]          lsu_wmask;
    logic [7:0]          lsu_rmask;
    logic                lsu_req_ready;
    logic                lsu_rvalid;
    logic [DATA_LEN-1:0] lsu_rdata;
    // shared SRAM side
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_wen;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [7:0]          mem_wmask;
    logic [7:0]          mem_rmask;
    logic                mem_rvalid;
    logic [DATA_LEN-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rvalid, ifu_rdata,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
        output lsu_req_ready, lsu_rvalid, lsu_rdata,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask,
        input  mem_req_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rvalid, ifu_rdata,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
        input  lsu_req_ready, lsu_rvalid, lsu_rdata,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask,
        output mem_req_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for one shared SRAM port.
// Exactly one transaction is in flight: IDLE grants, ISSUE presents the
// latched request until the SRAM accepts it, WAIT_RESP routes the single
// response back to the owner. Ties are broken round-robin via last_grant.
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22041211_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;             // 0 = IFU, 1 = LSU
    logic                last_grant_q, last_grant_d;
    logic                mem_wen_q, mem_wen_d;
    logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]          mem_wmask_q, mem_wmask_d;
    logic [7:0]          mem_rmask_q, mem_rmask_d;

    logic                grant_any;
    logic                grant_lsu;
    logic                ifu_req_ready;
    logic                lsu_req_ready;
    logic                mem_req_valid;
    logic                resp_fire;
    logic [1:0]          rsp_valid;
    logic [DATA_LEN-1:0] rsp_data [2];

    // LSU wins if it is alone, or on a tie when the IFU was granted last.
    assign grant_any = bus.ifu_req_valid | bus.lsu_req_valid;
    assign grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_grant_q);

    // Next-state, grant handshake and request-field capture.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        mem_wen_d     = mem_wen_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        mem_rmask_d   = mem_rmask_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    owner_d      = grant_lsu;
                    last_grant_d = grant_lsu;
                    state_d      = S_ISSUE;
                    if (grant_lsu) begin
                        lsu_req_ready = 1'b1;
                        mem_wen_d     = bus.lsu_wen;
                        mem_addr_d    = bus.lsu_addr;
                        mem_wdata_d   = bus.lsu_wdata;
                        mem_wmask_d   = bus.lsu_wmask;
                        mem_rmask_d   = bus.lsu_rmask;
                    end else begin
                        // Instruction fetch is always a 32-bit read.
                        ifu_req_ready = 1'b1;
                        mem_wen_d     = 1'b0;
                        mem_addr_d    = bus.ifu_addr;
                        mem_wdata_d   = '0;
                        mem_wmask_d   = 8'h00;
                        mem_rmask_d   = 8'h0F;
                    end
                end
            end
            S_ISSUE: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (bus.mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // No handshake is visible while reset is held.
        if (rst) begin
            ifu_req_ready = 1'b0;
            lsu_req_ready = 1'b0;
            mem_req_valid = 1'b0;
        end
    end

    // State, ownership and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= 8'h00;
            mem_rmask_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_rmask_q  <= mem_rmask_d;
        end
    end

    // A response is only meaningful while waiting; stray ones are dropped.
    assign resp_fire = ~rst & (state_q == S_WAIT_RESP) & bus.mem_rvalid;

    // Steer the response to its owner; the other requester sees zeros.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_valid[gi] = resp_fire & (owner_q == 1'(gi));
            assign rsp_data[gi]  = rsp_valid[gi] ? bus.mem_rdata : '0;
        end
    endgenerate

    assign bus.ifu_req_ready = ifu_req_ready;
    assign bus.lsu_req_ready = lsu_req_ready;
    assign bus.ifu_rvalid    = rsp_valid[0];
    assign bus.ifu_rdata     = rsp_data[0];
    assign bus.lsu_rvalid    = rsp_valid[1];
    assign bus.lsu_rdata     = rsp_data[1];
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.mem_rmask     = mem_rmask_q;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a per-cycle vector table
// followed by hand-written reset-in-flight and back-to-back fetch sequences.
module tb_ysyx_22041211_mem_arbiter;

    logic clk;
    logic rst;

    ysyx_22041211_mem_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    ysyx_22041211_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        // inputs
        logic        rst;
        logic        ifu_v;
        logic [31:0] ifu_addr;
        logic        lsu_v;
        logic        lsu_wen;
        logic [31:0] lsu_addr;
        logic [31:0] lsu_wdata;
        logic [7:0]  lsu_wmask;
        logic [7:0]  lsu_rmask;
        logic        mem_rdy;
        logic        mem_rv;
        logic [31:0] mem_rd;
        // expected outputs
        logic        e_ifu_rdy;
        logic        e_lsu_rdy;
        logic        e_ifu_rv;
        logic [31:0] e_ifu_rd;
        logic        e_lsu_rv;
        logic [31:0] e_lsu_rd;
        logic        e_mval;
        logic        chk_f;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [7:0]  e_wmask;
        logic [7:0]  e_rmask;
    } vec_t;

    vec_t vt [40];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic vin(input logic r, input logic iv, input logic [31:0] ia,
                       input logic lv, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld, input logic [7:0] lwm, input logic [7:0] lrm,
                       input logic mr, input logic mv, input logic [31:0] md);
        vt[n_vec].rst = r;        vt[n_vec].ifu_v = iv;      vt[n_vec].ifu_addr = ia;
        vt[n_vec].lsu_v = lv;     vt[n_vec].lsu_wen = lw;    vt[n_vec].lsu_addr = la;
        vt[n_vec].lsu_wdata = ld; vt[n_vec].lsu_wmask = lwm; vt[n_vec].lsu_rmask = lrm;
        vt[n_vec].mem_rdy = mr;   vt[n_vec].mem_rv = mv;     vt[n_vec].mem_rd = md;
    endtask

    task automatic vex(input logic ir, input logic lr, input logic irv, input logic [31:0] ird,
                       input logic lrv, input logic [31:0] lrd, input logic mval, input logic cf,
                       input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] wm, input logic [7:0] rm);
        vt[n_vec].e_ifu_rdy = ir;  vt[n_vec].e_lsu_rdy = lr;
        vt[n_vec].e_ifu_rv = irv;  vt[n_vec].e_ifu_rd = ird;
        vt[n_vec].e_lsu_rv = lrv;  vt[n_vec].e_lsu_rd = lrd;
        vt[n_vec].e_mval = mval;   vt[n_vec].chk_f = cf;
        vt[n_vec].e_wen = w;       vt[n_vec].e_addr = a;    vt[n_vec].e_wdata = d;
        vt[n_vec].e_wmask = wm;    vt[n_vec].e_rmask = rm;
        n_vec++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] ia,
                         input logic lv, input logic lw, input logic [31:0] la,
                         input logic [31:0] ld, input logic [7:0] lwm, input logic [7:0] lrm,
                         input logic mr, input logic mv, input logic [31:0] md);
        rst = r;
        bus.ifu_req_valid = iv; bus.ifu_addr = ia;
        bus.lsu_req_valid = lv; bus.lsu_wen = lw; bus.lsu_addr = la;
        bus.lsu_wdata = ld; bus.lsu_wmask = lwm; bus.lsu_rmask = lrm;
        bus.mem_req_ready = mr; bus.mem_rvalid = mv; bus.mem_rdata = md;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int grant_cyc [$];
    logic mem_acc;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, then a single IFU fetch with a one-cycle SRAM.
        vin(1,1,32'h8000_0000,1,0,0,0,8'h00,8'h0F,1,1,32'h1111_1111); vex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin(1,0,0,0,0,0,0,0,0,0,0,0);                                 vex(0,0,0,0,0,0,0,1,0,0,0,0,0);
        vin(0,1,32'h8000_0000,0,0,0,0,0,0,1,0,0);                     vex(1,0,0,0,0,0,0,1,0,0,0,0,0);
        vin(0,0,0,0,0,0,0,0,0,1,0,0);                                 vex(0,0,0,0,0,0,1,1,0,32'h8000_0000,0,8'h00,8'h0F);
        vin(0,0,0,0,0,0,0,0,0,0,1,32'h0000_0413);                     vex(0,0,1,32'h0000_0413,0,0,0,1,0,32'h8000_0000,0,8'h00,8'h0F);
        vin(0,0,0,0,0,0,0,0,0,0,0,0);                                 vex(0,0,0,0,0,0,0,1,0,32'h8000_0000,0,8'h00,8'h0F);
        // Reset again, then three ties: LSU, IFU, LSU.
        vin(1,0,0,0,0,0,0,0,0,0,0,0);                                 vex(0,0,0,0,0,0,0,0,0,0,0,0,0);
        vin(0,1,32'h8000_0004,1,0,32'h8000_2000,0,8'h00,8'h0F,1,0,0); vex(0,1,0,0,0,0,0,1,0,0,0,0,0);
        vin(0,1,32'h8000_0004,0,0,0,0,0,0,1,0,0);                     vex(0,0,0,0,0,0,1,1,0,32'h8000_2000,0,8'h00,8'h0F);
        vin(0,1,32'h8000_0004,0,0,0,0,0,0,1,1,32'h1234_5678);         vex(0,0,0,0,1,32'h1234_5678,0,1,0,32'h8000_2000,0,8'h00,8'h0F);
        vin(0,1,32'h8000_0004,1,0,32'h8000_2004,0,8'h00,8'h0F,1,0,0); vex(1,0,0,0,0,0,0,1,0,32'h8000_2000,0,8'h00,8'h0F);
        vin(0,0,0,1,0,32'h8000_2004,0,8'h00,8'h0F,1,0,0);             vex(0,0,0,0,0,0,1,1,0,32'h8000_0004,0,8'h00,8'h0F);
        vin(0,1,32'h8000_000C,1,0,32'h8000_2004,0,8'h00,8'h0F,1,1,32'h0000_0093); vex(0,0,1,32'h0000_0093,0,0,0,1,0,32'h8000_0004,0,8'h00,8'h0F);
        vin(0,1,32'h8000_000C,1,0,32'h8000_2004,0,8'h00,8'h0F,1,0,0); vex(0,1,0,0,0,0,0,1,0,32'h8000_0004,0,8'h00,8'h0F);
        vin(0,0,0,0,0,0,0,0,0,1,0,0);                                 vex(0,0,0,0,0,0,1,1,0,32'h8000_2004,0,8'h00,8'h0F);
        vin(0,0,0,0,0,0,0,0,0,1,1,32'hAABB_CCDD);                     vex(0,0,0,0,1,32'hAABB_CCDD,0,1,0,32'h8000_2004,0,8'h00,8'h0F);
        // LSU store with the SRAM stalling four cycles; a stray rvalid in ISSUE.
        vin(0,0,0,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00,0,0,0); vex(0,1,0,0,0,0,0,1,0,32'h8000_2004,0,8'h00,8'h0F);
        vin(0,1,32'h8000_0010,0,0,0,0,0,0,0,0,0);                     vex(0,0,0,0,0,0,1,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        vin(0,1,32'h8000_0010,0,0,0,0,0,0,0,1,32'h7777_7777);         vex(0,0,0,0,0,0,1,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        vin(0,1,32'h8000_0010,0,0,0,0,0,0,0,0,0);                     vex(0,0,0,0,0,0,1,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        vin(0,1,32'h8000_0010,0,0,0,0,0,0,0,0,0);                     vex(0,0,0,0,0,0,1,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        vin(0,1,32'h8000_0010,0,0,0,0,0,0,1,0,0);                     vex(0,0,0,0,0,0,1,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        vin(0,1,32'h8000_0010,0,0,0,0,0,0,0,0,0);                     vex(0,0,0,0,0,0,0,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        vin(0,0,0,0,0,0,0,0,0,0,1,32'h5555_5555);                     vex(0,0,0,0,1,32'h5555_5555,0,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        // Spurious SRAM response in IDLE, then a grant proving IDLE was kept.
        vin(0,0,0,0,0,0,0,0,0,0,1,32'hFFFF_FFFF);                     vex(0,0,0,0,0,0,0,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);
        vin(0,1,32'h8000_0010,0,0,0,0,0,0,1,0,0);                     vex(1,0,0,0,0,0,0,1,1,32'h8000_1004,32'hDEAD_BEEF,8'h0F,8'h00);

        @(posedge clk);
        #1;
        for (int i = 0; i < n_vec; i++) begin
            drive(vt[i].rst, vt[i].ifu_v, vt[i].ifu_addr, vt[i].lsu_v, vt[i].lsu_wen,
                  vt[i].lsu_addr, vt[i].lsu_wdata, vt[i].lsu_wmask, vt[i].lsu_rmask,
                  vt[i].mem_rdy, vt[i].mem_rv, vt[i].mem_rd);
            @(negedge clk);
            chk($sformatf("v%0d ifu_req_ready", i), 32'(bus.ifu_req_ready), 32'(vt[i].e_ifu_rdy));
            chk($sformatf("v%0d lsu_req_ready", i), 32'(bus.lsu_req_ready), 32'(vt[i].e_lsu_rdy));
            chk($sformatf("v%0d ifu_rvalid", i),    32'(bus.ifu_rvalid),    32'(vt[i].e_ifu_rv));
            chk($sformatf("v%0d ifu_rdata", i),     bus.ifu_rdata,          vt[i].e_ifu_rd);
            chk($sformatf("v%0d lsu_rvalid", i),    32'(bus.lsu_rvalid),    32'(vt[i].e_lsu_rv));
            chk($sformatf("v%0d lsu_rdata", i),     bus.lsu_rdata,          vt[i].e_lsu_rd);
            chk($sformatf("v%0d mem_req_valid", i), 32'(bus.mem_req_valid), 32'(vt[i].e_mval));
            if (vt[i].chk_f) begin
                chk($sformatf("v%0d mem_wen", i),   32'(bus.mem_wen),   32'(vt[i].e_wen));
                chk($sformatf("v%0d mem_addr", i),  bus.mem_addr,       vt[i].e_addr);
                chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata,      vt[i].e_wdata);
                chk($sformatf("v%0d mem_wmask", i), 32'(bus.mem_wmask), 32'(vt[i].e_wmask));
                chk($sformatf("v%0d mem_rmask", i), 32'(bus.mem_rmask), 32'(vt[i].e_rmask));
            end
            $display("vec %0d: rst=%0b ifu_rdy=%0b lsu_rdy=%0b ifu_rv=%0b lsu_rv=%0b mval=%0b addr=%08h",
                     i, rst, bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rvalid,
                     bus.lsu_rvalid, bus.mem_req_valid, bus.mem_addr);
            next_cycle();
        end

        // Reset during WAIT_RESP after an LSU grant, then a late response.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 1, 0, 32'h8000_3000, 0, 8'h00, 8'h0F, 1, 0, 0);
        @(negedge clk);
        chk("rstwait grant lsu", 32'(bus.lsu_req_ready), 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("rstwait issue", 32'(bus.mem_req_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("rstwait waiting lsu_rvalid", 32'(bus.lsu_rvalid), 32'd0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("rstwait in-reset lsu_rvalid", 32'(bus.lsu_rvalid), 32'd0);
        chk("rstwait in-reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        next_cycle();
        drive(0, 1, 32'h8000_0020, 1, 0, 32'h8000_3004, 0, 8'h00, 8'h0F, 1, 1, 32'h0000_0BAD);
        @(negedge clk);
        chk("rstwait late ifu_rvalid", 32'(bus.ifu_rvalid), 32'd0);
        chk("rstwait late lsu_rvalid", 32'(bus.lsu_rvalid), 32'd0);
        chk("rstwait tie lsu_req_ready", 32'(bus.lsu_req_ready), 32'd1);
        chk("rstwait tie ifu_req_ready", 32'(bus.ifu_req_ready), 32'd0);
        $display("seq rstwait: late rvalid dropped, tie ifu_rdy=%0b lsu_rdy=%0b",
                 bus.ifu_req_ready, bus.lsu_req_ready);
        next_cycle();

        // Back-to-back IFU fetches against a one-cycle SRAM.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        mem_acc = 1'b0;
        for (int c = 0; c < 30; c++) begin
            drive(0, 1, 32'h8000_0000 + 32'(4 * c), 0, 0, 0, 0, 0, 0, 1, mem_acc, 32'h0000_0013);
            @(negedge clk);
            if (bus.ifu_req_ready) grant_cyc.push_back(c);
            mem_acc = bus.mem_req_valid & bus.mem_req_ready;
            next_cycle();
        end
        chk("stream grant count", 32'(grant_cyc.size()), 32'd10);
        for (int k = 1; k < grant_cyc.size(); k++) begin
            chk($sformatf("stream gap %0d", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd3);
        end
        $display("seq stream: %0d grants in 30 cycles", grant_cyc.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
